div_share_ctrl: RTL and testbench

DIV_SHARE_CTRL -- requirements
Module: div_share_ctrl

---
 rtl/div_share_ctrl.sv | 127 ++++++++++++
 tb/tb_div_share_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// Shared unsigned divider for two requesters. A round-robin arbiter grants
// one request at a time; the granted operands are divided by a restoring
// shift-subtract engine that produces one quotient bit per cycle.
module div_share_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] dividend0,
  input  logic [WIDTH-1:0] divisor0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dividend1,
  input  logic [WIDTH-1:0] divisor1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;      // partial remainder, one bit wider than operands
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             qbit;
  logic             gnt_id;
  logic             any_gnt;
  logic             last_iter;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;

  // Round-robin arbiter: on a tie, the requester other than `last` wins.
  // Gated by rst so the grant reads zero while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (state == IDLE && !rst) begin
      if (req0 && (!req1 || last)) begin
        gnt = 2'b01;
      end else if (req1) begin
        gnt = 2'b10;
      end
    end
  end

  assign gnt_id    = gnt[1];
  assign any_gnt   = |gnt;
  assign sel_dvd   = gnt_id ? dividend1 : dividend0;
  assign sel_dvs   = gnt_id ? divisor1 : divisor0;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    qbit     = (trial >= {1'b0, dvs});
    prem_nxt = qbit ? (trial - {1'b0, dvs}) : trial;
    dvd_nxt  = (dvd << 1) | WIDTH'(qbit);
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_gnt) state_nxt = (sel_dvs == '0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= 1'b1;
      done_id     <= 1'b0;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE && any_gnt) begin
      last    <= gnt_id;
      done_id <= gnt_id;
      dvd     <= sel_dvd;
      dvs     <= sel_dvs;
      prem    <= '0;
      cnt     <= '0;
      if (sel_dvs == '0) begin
        quotient    <= '1;
        remainder   <= sel_dvd;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      prem <= prem_nxt;
      dvd  <= dvd_nxt;
      cnt  <= cnt + CNT_W'(1);
      if (last_iter) begin
        quotient    <= dvd_nxt;
        remainder   <= prem_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Randomised and directed bench for div_share_ctrl against an arithmetic
// reference model (a/b, a%b, round-robin fairness, fixed latency).
module tb_div_share_ctrl;

  localparam int W = 8;

  logic         clk, rst;
  logic         req0, req1;
  logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
  logic [1:0]   gnt;
  logic         busy, done, done_id, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  int           m_cnt;   // cycles until the done cycle (0 = idle)
  bit           m_last;
  bit           m_id;
  bit           m_z;
  logic [W-1:0] m_q, m_r;

  div_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .dividend0(dividend0), .divisor0(divisor0),
    .req1(req1), .dividend1(dividend1), .divisor1(divisor1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already set for the coming rising edge.
  task automatic cycle(output int g);
    int           pick;
    logic [1:0]   eg;
    logic [W-1:0] a, b;
    #1;
    pick = -1;
    if (m_cnt == 0) begin
      if (req0 && req1) pick = m_last ? 0 : 1;
      else if (req0)    pick = 0;
      else if (req1)    pick = 1;
    end
    eg = (pick == 0) ? 2'b01 : (pick == 1) ? 2'b10 : 2'b00;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("busy", 32'(busy), 32'(m_cnt != 0));
    check_eq("done", 32'(done), 32'(m_cnt == 1));
    if (m_cnt == 1) begin
      check_eq("quotient", 32'(quotient), 32'(m_q));
      check_eq("remainder", 32'(remainder), 32'(m_r));
      check_eq("div_by_zero", 32'(div_by_zero), 32'(m_z));
      check_eq("done_id", 32'(done_id), 32'(m_id));
    end
    if (m_cnt > 0) begin
      m_cnt--;
    end else if (pick >= 0) begin
      a      = (pick == 1) ? dividend1 : dividend0;
      b      = (pick == 1) ? divisor1 : divisor0;
      m_id   = (pick == 1);
      m_last = (pick == 1);
      if (b == 0) begin
        m_q = '1; m_r = a; m_z = 1'b1; m_cnt = 1;
      end else begin
        m_q = a / b; m_r = a % b; m_z = 1'b0; m_cnt = W + 1;
      end
    end
    g = pick;
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_done_id", 32'(done_id), 32'd0);
    check_eq("rst_quotient", 32'(quotient), 32'd0);
    check_eq("rst_remainder", 32'(remainder), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_last = 1'b1; m_id = 1'b0; m_z = 1'b0; m_q = '0; m_r = '0;
  endtask

  // Hold requests until granted (or for `ops` grants when keep is set), then drain.
  task automatic run(input bit r0, input bit r1, input bit keep,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input int ops);
    int g;
    int n;
    n = 0;
    req0 = r0; req1 = r1;
    dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1;
    for (int c = 0; c < (ops + 2) * (W + 4); c++) begin
      cycle(g);
      if (g >= 0) begin
        n++;
        if (n >= ops) begin
          req0 = 1'b0; req1 = 1'b0;
        end else if (!keep) begin
          if (g == 0) req0 = 1'b0;
          else        req1 = 1'b0;
        end
        // captured operands must no longer matter
        if (g == 0) begin dividend0 = W'($urandom); divisor0 = W'($urandom); end
        else        begin dividend1 = W'($urandom); divisor1 = W'($urandom); end
      end
      if (!req0 && !req1 && m_cnt == 0) return;
    end
    nvec++; nerr++;
    $display("FAIL run_timeout: got busy/req still pending, required completion (t=%0t)", $time);
  endtask

  initial begin
    int g;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    @(negedge clk);
    do_reset();

    run(1, 0, 0, 8'd15, 8'd3, 8'd0, 8'd0, 1);
    run(1, 1, 0, 8'd28, 8'd5, 8'd100, 8'd20, 2);
    run(1, 1, 1, 8'd200, 8'd7, 8'd77, 8'd9, 6);
    run(0, 1, 0, 8'd0, 8'd0, 8'd123, 8'd0, 1);
    run(1, 0, 0, 8'd123, 8'd6, 8'd0, 8'd0, 1);
    run(1, 0, 0, 8'd255, 8'd1, 8'd0, 8'd0, 1);
    run(0, 1, 0, 8'd0, 8'd0, 8'd5, 8'd9, 1);
    run(1, 0, 0, 8'd255, 8'd255, 8'd0, 8'd0, 1);

    // Abort mid-CALC, then a fresh operation.
    req0 = 1'b1; dividend0 = 8'd100; divisor0 = 8'd3;
    cycle(g);
    req0 = 1'b0;
    cycle(g);
    cycle(g);
    do_reset();
    cycle(g);
    run(1, 0, 0, 8'd100, 8'd7, 8'd0, 8'd0, 1);

    // Random traffic, including dropped requests and zero divisors.
    for (int c = 0; c < 3000; c++) begin
      req0      = 1'($urandom_range(0, 1));
      req1      = 1'($urandom_range(0, 1));
      dividend0 = W'($urandom);
      dividend1 = W'($urandom);
      divisor0  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 1 << W));
      divisor1  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
      cycle(g);
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < W + 4; c++) cycle(g);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
